// File: rtl/epl_write_demux_sub_if.sv
// Write-request / status bundle between the macro controller and epl_write_demux_sub.
// pBwe_i exists only when EPL_WR_BITMASK_EN is defined.
`ifndef TWORD_WIDTH
`define TWORD_WIDTH 8
`endif
`ifndef MUX
`define MUX 2
`endif
`ifndef COLUMN
`define COLUMN (`TWORD_WIDTH * `MUX)
`endif
`ifndef ADDR_AYO
`define ADDR_AYO 2
`endif

interface epl_write_demux_sub_if;
    logic                    pWrite_i;
    logic [`TWORD_WIDTH-1:0] pDi_i;
    logic [`ADDR_AYO-1:0]    pAcy2_i;
`ifdef EPL_WR_BITMASK_EN
    logic [`TWORD_WIDTH-1:0] pBwe_i;
`endif
    logic [`COLUMN-1:0]      pDti_o;
    logic [`COLUMN-1:0]      pCen_o;
    logic                    pWpls_o;
    logic                    pBusy_o;
    logic                    pWdone_o;
    logic                    pWerr_o;

    modport master (
        output pWrite_i, pDi_i, pAcy2_i,
`ifdef EPL_WR_BITMASK_EN
        output pBwe_i,
`endif
        input  pDti_o, pCen_o, pWpls_o, pBusy_o, pWdone_o, pWerr_o
    );

    modport slave (
        input  pWrite_i, pDi_i, pAcy2_i,
`ifdef EPL_WR_BITMASK_EN
        input  pBwe_i,
`endif
        output pDti_o, pCen_o, pWpls_o, pBusy_o, pWdone_o, pWerr_o
    );
endinterface

// File: rtl/epl_write_demux_sub.sv
// Write-path column demux: spreads a word onto even/odd columns and sequences setup/pulse/hold.
// Per-bit write mask is compiled in when EPL_WR_BITMASK_EN is defined.
`ifndef TWORD_WIDTH
`define TWORD_WIDTH 8
`endif
`ifndef MUX
`define MUX 2
`endif
`ifndef COLUMN
`define COLUMN (`TWORD_WIDTH * `MUX)
`endif
`ifndef ADDR_AYO
`define ADDR_AYO 2
`endif

module epl_write_demux_sub #(
    parameter int unsigned WPULSE_CYC = 4
) (
    input logic                  pClk_i,
    input logic                  nRst_i,
    epl_write_demux_sub_if.slave wr_io
);
    localparam int unsigned Tw  = `TWORD_WIDTH;
    localparam int unsigned Col = `COLUMN;
    localparam int unsigned Ayo = `ADDR_AYO;

    typedef enum logic [1:0] {StIdle, StSetup, StPulse, StHold} state_e;

    state_e         state_q, state_d;
    logic [7:0]     cnt_q, cnt_d;
    logic [Tw-1:0]  data_q, data_d;
    logic [Tw-1:0]  en_q, en_d;
    logic [Ayo-1:0] sel_q, sel_d;

    logic [Col-1:0] dti_q, dti_d;
    logic [Col-1:0] cen_q, cen_d;
    logic           wpls_q, wpls_d;
    logic           busy_q, busy_d;
    logic           wdone_q, wdone_d;
    logic           werr_q, werr_d;

    logic           sel_ok;
    logic [Tw-1:0]  en_in;

    assign sel_ok = (wr_io.pAcy2_i == 2'b01) || (wr_io.pAcy2_i == 2'b10);

`ifdef EPL_WR_BITMASK_EN
    assign en_in = wr_io.pBwe_i;
`else
    assign en_in = '1;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        en_d    = en_q;
        sel_d   = sel_q;
        werr_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (wr_io.pWrite_i) begin
                    if (sel_ok) begin
                        data_d  = wr_io.pDi_i;
                        en_d    = en_in;
                        sel_d   = wr_io.pAcy2_i;
                        state_d = StSetup;
                    end else begin
                        werr_d = 1'b1;
                    end
                end
            end
            StSetup: begin
                cnt_d   = 8'(WPULSE_CYC - 1);
                state_d = StPulse;
            end
            StPulse: begin
                if (cnt_q == 8'd0) begin
                    state_d = StHold;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            StHold: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // A request while the engine is occupied is dropped; the running write continues.
        if (wr_io.pWrite_i && (state_q != StIdle)) begin
            werr_d = 1'b1;
        end
    end

    // Outputs are computed from next-state values so that every output is a plain register.
    always_comb begin
        dti_d = '0;
        cen_d = '0;
        if (state_d != StIdle) begin
            for (int i = 0; i < int'(Tw); i++) begin
                dti_d[2*i]   = (sel_d == 2'b01) & data_d[i] & en_d[i];
                cen_d[2*i]   = (sel_d == 2'b01) & en_d[i];
                dti_d[2*i+1] = (sel_d == 2'b10) & data_d[i] & en_d[i];
                cen_d[2*i+1] = (sel_d == 2'b10) & en_d[i];
            end
        end
        busy_d  = (state_d != StIdle);
        wpls_d  = (state_d == StPulse);
        wdone_d = (state_d == StHold);
    end

    always_ff @(posedge pClk_i or negedge nRst_i) begin
        if (!nRst_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            data_q  <= '0;
            en_q    <= '0;
            sel_q   <= '0;
            dti_q   <= '0;
            cen_q   <= '0;
            wpls_q  <= 1'b0;
            busy_q  <= 1'b0;
            wdone_q <= 1'b0;
            werr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            en_q    <= en_d;
            sel_q   <= sel_d;
            dti_q   <= dti_d;
            cen_q   <= cen_d;
            wpls_q  <= wpls_d;
            busy_q  <= busy_d;
            wdone_q <= wdone_d;
            werr_q  <= werr_d;
        end
    end

    assign wr_io.pDti_o   = dti_q;
    assign wr_io.pCen_o   = cen_q;
    assign wr_io.pWpls_o  = wpls_q;
    assign wr_io.pBusy_o  = busy_q;
    assign wr_io.pWdone_o = wdone_q;
    assign wr_io.pWerr_o  = werr_q;
endmodule

// File: tb/tb_epl_write_demux_sub.sv
// Scoreboard bench for epl_write_demux_sub (TWORD_WIDTH=8, COLUMN=16, WPULSE_CYC=4).
// Define EPL_WR_BITMASK_EN to also exercise the per-bit write mask.
module tb_epl_write_demux_sub;
    localparam int WP = 4;

    logic clk = 1'b0;
    logic rst_n;

    epl_write_demux_sub_if bus ();

    epl_write_demux_sub #(
        .WPULSE_CYC(WP)
    ) dut (
        .pClk_i(clk),
        .nRst_i(rst_n),
        .wr_io (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] dti;
        logic [15:0] cen;
    } exp_t;

    exp_t wq[$];
    int   eq[$];
    int   checks   = 0;
    int   failures = 0;
    int   idx      = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Monitor: one pass per cycle, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            idx = 0;
        end else begin
            if (bus.pBusy_o) begin
                idx++;
                if (wq.size() == 0) begin
                    chk("busy_without_write", 32'(bus.pBusy_o), 32'd0);
                end else begin
                    chk("dti", 32'(bus.pDti_o), 32'(wq[0].dti));
                    chk("cen", 32'(bus.pCen_o), 32'(wq[0].cen));
                    chk("wpls", 32'(bus.pWpls_o), 32'((idx >= 2) && (idx <= WP + 1)));
                    chk("wdone", 32'(bus.pWdone_o), 32'(idx == WP + 2));
                    if (bus.pWdone_o) void'(wq.pop_front());
                end
            end else begin
                if (idx != 0) chk("busy_len", 32'(idx), 32'(WP + 2));
                idx = 0;
                chk("idle_dti", 32'(bus.pDti_o), 32'd0);
                chk("idle_cen", 32'(bus.pCen_o), 32'd0);
                chk("idle_wpls", 32'(bus.pWpls_o), 32'd0);
                chk("idle_wdone", 32'(bus.pWdone_o), 32'd0);
            end
            if (bus.pWerr_o) begin
                if (eq.size() == 0) chk("unexpected_werr", 32'(bus.pWerr_o), 32'd0);
                else begin
                    chk("werr", 32'(bus.pWerr_o), 32'd1);
                    void'(eq.pop_front());
                end
            end
        end
    end

    // Called just after an edge; the request is sampled at the following edge.
    task automatic issue(input logic [7:0] d, input logic [1:0] sel, input logic [7:0] bwe,
                         input bit push, input logic [15:0] edti, input logic [15:0] ecen,
                         input bit err);
        exp_t e;
        bus.pWrite_i = 1'b1;
        bus.pDi_i    = d;
        bus.pAcy2_i  = sel;
`ifdef EPL_WR_BITMASK_EN
        bus.pBwe_i   = bwe;
`endif
        if (push) begin
            e.dti = edti;
            e.cen = ecen;
            wq.push_back(e);
        end
        if (err) eq.push_back(1);
        @(posedge clk);
        #1;
        bus.pWrite_i = 1'b0;
        bus.pDi_i    = ~d;
        bus.pAcy2_i  = 2'b11;
`ifdef EPL_WR_BITMASK_EN
        bus.pBwe_i   = ~bwe;
`endif
    endtask

    task automatic wait_edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(string tag);
        chk({tag, "_dti"}, 32'(bus.pDti_o), 32'd0);
        chk({tag, "_cen"}, 32'(bus.pCen_o), 32'd0);
        chk({tag, "_wpls"}, 32'(bus.pWpls_o), 32'd0);
        chk({tag, "_busy"}, 32'(bus.pBusy_o), 32'd0);
        chk({tag, "_wdone"}, 32'(bus.pWdone_o), 32'd0);
        chk({tag, "_werr"}, 32'(bus.pWerr_o), 32'd0);
    endtask

    initial begin
        rst_n        = 1'b0;
        bus.pWrite_i = 1'b0;
        bus.pDi_i    = 8'h00;
        bus.pAcy2_i  = 2'b00;
`ifdef EPL_WR_BITMASK_EN
        bus.pBwe_i   = 8'hFF;
`endif
        wait_edges(3);
        chk_all_zero("reset");
        rst_n = 1'b1;
        wait_edges(3);
        chk("post_reset_busy", 32'(bus.pBusy_o), 32'd0);

        // Even write, then back-to-back odd and even writes accepted at T+7.
        issue(8'hA5, 2'b01, 8'hFF, 1'b1, 16'h4411, 16'h5555, 1'b0);
        wait_edges(6);
        issue(8'hFF, 2'b10, 8'hFF, 1'b1, 16'hAAAA, 16'hAAAA, 1'b0);
        wait_edges(6);
        issue(8'h3C, 2'b01, 8'hFF, 1'b1, 16'h0550, 16'h5555, 1'b0);
        wait_edges(8);

        // Illegal column selects in IDLE.
        issue(8'h5A, 2'b11, 8'hFF, 1'b0, 16'h0, 16'h0, 1'b1);
        wait_edges(1);
        issue(8'h5A, 2'b00, 8'hFF, 1'b0, 16'h0, 16'h0, 1'b1);
        wait_edges(2);
        chk("err_no_busy", 32'(bus.pBusy_o), 32'd0);

        // Request during the first pulse cycle must not disturb the running write.
        issue(8'h81, 2'b10, 8'hFF, 1'b1, 16'h8002, 16'hAAAA, 1'b0);
        wait_edges(1);
        issue(8'h00, 2'b01, 8'hFF, 1'b0, 16'h0, 16'h0, 1'b1);
        wait_edges(8);

`ifdef EPL_WR_BITMASK_EN
        issue(8'hFF, 2'b01, 8'h0F, 1'b1, 16'h0055, 16'h0055, 1'b0);
        wait_edges(8);
`endif

        // Reset in the second pulse cycle.
        issue(8'hA5, 2'b01, 8'hFF, 1'b1, 16'h4411, 16'h5555, 1'b0);
        wait_edges(2);
        chk("pre_abort_wpls", 32'(bus.pWpls_o), 32'd1);
        rst_n = 1'b0;
        wq.delete();
        #1;
        chk_all_zero("abort");
        wait_edges(2);
        rst_n = 1'b1;
        wait_edges(8);
        chk("abort_no_busy", 32'(bus.pBusy_o), 32'd0);

        chk("write_queue_empty", 32'(wq.size()), 32'd0);
        chk("err_queue_empty", 32'(eq.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end
endmodule
